ra_spec_stack: RTL and testbench
================================

Name: ra_spec_stack

Overview:
Speculative return-address stack with commit-side shadow and recovery.
- Fetch side pushes on predicted calls and pops on predicted returns; it supplies the return-address prediction with zero latency.
- Commit side keeps an architecturally correct copy, updated by retired calls and returns.
- On a pipeline flush (mispredict/exception) the speculative stack is restored from the committed copy in one cycle.
- Both stacks are circular: overflow overwrites the oldest entry and never stalls.

Parameters:
ADDR, `AddrWidth (32), address width.
RA_DEPTH, `RaStackDepth (8), entries per stack; power of two, >= 2.
INCR, `InstWidth/`ByteBitWidth (4), localparam, return offset added to a call pc.

Ports:
clk  in  1  clock.
reset  in  1  asynchronous reset, active-high.
fetch_call_  in  1  active-low; speculative call fetched; push.
fetch_pc  in  ADDR  pc of fetched call.
fetch_ret_  in  1  active-low; speculative return fetched; pop.
ret_v  out  1  speculative top entry valid.
ret_addr  out  ADDR  speculative top-of-stack return address.
commit_call_  in  1  active-low; call retired; push to committed stack.
commit_pc  in  ADDR  pc of retired call.
commit_ret_  in  1  active-low; return retired; pop committed stack.
flush_  in  1  active-low; restore speculative stack from committed stack.
ovf  out  1  one-cycle pulse: speculative push overwrote oldest entry.

Behaviour:
- State per stack: mem[RA_DEPTH] of ADDR, ptr (log2 RA_DEPTH bits, index of top), cnt (0..RA_DEPTH).
- Reset (async, immediate): all mem = 0, ptr = 0, cnt = 0 for both stacks. Outputs: ret_v = 0, ret_addr = 0, ovf = 0.
- Pushed value is pc + INCR, truncated to ADDR bits (wraps).
- Push only: ptr <= ptr+1 (mod RA_DEPTH), mem[ptr+1] <= value, cnt <= min(cnt+1, RA_DEPTH).
  - When cnt == RA_DEPTH, the write overwrites the oldest entry.
  - In the speculative stack this asserts ovf for the next cycle only.
- Pop only: if cnt > 0, ptr <= ptr-1 and cnt <= cnt-1. If cnt == 0, no-op; no error.
- Push and pop in the same cycle (same stack): pop-then-push.
  - If cnt > 0: mem[ptr] <= value; ptr and cnt unchanged.
  - If cnt == 0: plain push.
- ret_v = (spec cnt != 0); ret_addr = spec mem[spec ptr].
  - Both are driven directly from registers; no combinational path from inputs.
  - Ops take effect on the following cycle.
- Committed stack updates every cycle from the commit_* inputs, independent of flush_.
- flush_ asserted:
  - spec mem/ptr/cnt <= the committed stack's next-state value, i.e. including any commit op in the same cycle.
  - fetch_call_ and fetch_ret_ in that cycle are ignored.
  - ovf is not asserted as a result of the flush.
- Popped/overwritten entries are not cleared. When ret_v = 0, ret_addr shows the stale mem[ptr] and is don't-care for consumers.
- No busy/backpressure; every op is accepted every cycle.

Decomposition:
- AddrWidth, RaStackDepth, InstWidth and ByteBitWidth come from the shared cpu_config header; the ptr width is derived locally via $clog2.
- Natural sub-module: ra_stack_core. It is a circular stack with push/pop/replace semantics and an optional full-state load port (load_, load_mem, load_ptr, load_cnt), which has priority over push/pop.
- ra_stack_core is instantiated twice:
  - committed instance: load tied off;
  - speculative instance: loaded from the committed instance's next-state outputs on flush_.

Test Plan:
1. Reset mid-operation (after 3 pushes), assert reset -> ret_v=0, ret_addr=0, ovf=0 immediately, with no clock edge needed.
2. fetch_call pc 0x100, then 0x200 -> ret_addr=0x204, ret_v=1.
   - fetch_ret -> 0x104.
   - fetch_ret -> ret_v=0.
   - extra fetch_ret -> cnt stays 0, no change.
3. RA_DEPTH=4; fetch_call pcs 0x10, 0x20, 0x30, 0x40, 0x50 -> ovf pulses one cycle after the 5th push only.
   - Successive pops return 0x54, 0x44, 0x34, 0x24, then ret_v=0.
4. Recovery: commit_call 0x100; fetch_call 0x100, fetch_call 0x300, fetch_ret; assert flush_ -> next cycle ret_addr=0x104, ret_v=1, spec cnt=1.
5. In one cycle assert flush_, commit_call pc 0x500 and fetch_call pc 0x900, with committed cnt=0 -> next cycle ret_addr=0x504 and cnt=1; 0x904 absent.
6. Spec top 0x104 (cnt=1); fetch_call 0x700 with fetch_ret in the same cycle -> ret_addr=0x704, cnt=1, ovf=0.
   - Repeat with cnt=0 -> ret_addr=0x704, cnt=1.

Source files
------------

// File: rtl/ra_spec_stack_pkg.sv
// Shared widths and helpers for the speculative return-address stack.
package ra_spec_stack_pkg;

   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned RA_STACK_DEPTH = 8;
   localparam int unsigned INST_W         = 32;
   localparam int unsigned BYTE_W         = 8;
   localparam int unsigned INCR           = INST_W / BYTE_W;

   // Return target of a call: the instruction after it, wrapping at ADDR_W.
   function automatic logic [ADDR_W-1:0] ret_target(input logic [ADDR_W-1:0] pc);
      return ADDR_W'(pc + ADDR_W'(INCR));
   endfunction

endpackage

// File: rtl/ra_spec_stack_if.sv
// Fetch/commit/flush bundle between the pipeline and the return-address stack.
interface ra_spec_stack_if;
   import ra_spec_stack_pkg::*;

   logic              fetch_call_;
   logic [ADDR_W-1:0] fetch_pc;
   logic              fetch_ret_;
   logic              ret_v;
   logic [ADDR_W-1:0] ret_addr;
   logic              commit_call_;
   logic [ADDR_W-1:0] commit_pc;
   logic              commit_ret_;
   logic              flush_;
   logic              ovf;

   modport master (
      output fetch_call_, fetch_pc, fetch_ret_,
      output commit_call_, commit_pc, commit_ret_, flush_,
      input  ret_v, ret_addr, ovf
   );

   modport slave (
      input  fetch_call_, fetch_pc, fetch_ret_,
      input  commit_call_, commit_pc, commit_ret_, flush_,
      output ret_v, ret_addr, ovf
   );

endinterface

// File: rtl/ra_spec_stack_core.sv
// Circular stack with push/pop/replace and a priority full-state load port.
module ra_spec_stack_core
   import ra_spec_stack_pkg::*;
#(
   parameter  int unsigned DEPTH = RA_STACK_DEPTH,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         i_push_,
   input  logic                         i_pop_,
   input  logic [ADDR_W-1:0]            i_push_val,
   input  logic                         i_load_,
   input  logic [DEPTH-1:0][ADDR_W-1:0] i_load_mem,
   input  logic [PTR_W-1:0]             i_load_ptr,
   input  logic [CNT_W-1:0]             i_load_cnt,
   output logic [DEPTH-1:0][ADDR_W-1:0] o_mem,
   output logic [PTR_W-1:0]             o_ptr,
   output logic [CNT_W-1:0]             o_cnt,
   output logic [DEPTH-1:0][ADDR_W-1:0] o_nxt_mem_c,
   output logic [PTR_W-1:0]             o_nxt_ptr_c,
   output logic [CNT_W-1:0]             o_nxt_cnt_c,
   output logic                         o_wrap_c
);

   logic [DEPTH-1:0][ADDR_W-1:0] r_mem;
   logic [PTR_W-1:0]             r_ptr;
   logic [CNT_W-1:0]             r_cnt;
   logic [PTR_W-1:0]             w_ptr_inc;
   logic                         w_full;
   logic                         w_empty;

   assign w_ptr_inc = r_ptr + PTR_W'(1);
   assign w_full    = (r_cnt == CNT_W'(DEPTH));
   assign w_empty   = (r_cnt == '0);

   // Next state: load wins, then replace (push+pop on non-empty), push, pop.
   always_comb begin
      o_nxt_mem_c = r_mem;
      o_nxt_ptr_c = r_ptr;
      o_nxt_cnt_c = r_cnt;
      o_wrap_c    = 1'b0;
      if (!i_load_) begin
         o_nxt_mem_c = i_load_mem;
         o_nxt_ptr_c = i_load_ptr;
         o_nxt_cnt_c = i_load_cnt;
      end else if (!i_push_ && !i_pop_ && !w_empty) begin
         o_nxt_mem_c[r_ptr] = i_push_val;
      end else if (!i_push_) begin
         o_nxt_ptr_c            = w_ptr_inc;
         o_nxt_mem_c[w_ptr_inc] = i_push_val;
         o_nxt_cnt_c            = w_full ? r_cnt : r_cnt + CNT_W'(1);
         o_wrap_c               = w_full;
      end else if (!i_pop_ && !w_empty) begin
         o_nxt_ptr_c = r_ptr - PTR_W'(1);
         o_nxt_cnt_c = r_cnt - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem <= '0;
         r_ptr <= '0;
         r_cnt <= '0;
      end else begin
         r_mem <= o_nxt_mem_c;
         r_ptr <= o_nxt_ptr_c;
         r_cnt <= o_nxt_cnt_c;
      end
   end

   assign o_mem = r_mem;
   assign o_ptr = r_ptr;
   assign o_cnt = r_cnt;

endmodule

// File: rtl/ra_spec_stack.sv
// Speculative return-address stack, restored in one cycle from a committed shadow on flush.
module ra_spec_stack
   import ra_spec_stack_pkg::*;
#(
   parameter  int unsigned RA_DEPTH = RA_STACK_DEPTH,
   localparam int unsigned PTR_W    = $clog2(RA_DEPTH),
   localparam int unsigned CNT_W    = $clog2(RA_DEPTH + 1)
) (
   input  logic            clk,
   input  logic            reset,
   ra_spec_stack_if.slave  bus
);

   logic [RA_DEPTH-1:0][ADDR_W-1:0] w_cmt_nxt_mem;
   logic [PTR_W-1:0]                w_cmt_nxt_ptr;
   logic [CNT_W-1:0]                w_cmt_nxt_cnt;
   logic [RA_DEPTH-1:0][ADDR_W-1:0] w_cmt_mem;
   logic [PTR_W-1:0]                w_cmt_ptr;
   logic [CNT_W-1:0]                w_cmt_cnt;
   logic                            w_cmt_wrap;

   logic [RA_DEPTH-1:0][ADDR_W-1:0] w_spec_mem;
   logic [PTR_W-1:0]                w_spec_ptr;
   logic [CNT_W-1:0]                w_spec_cnt;
   logic [RA_DEPTH-1:0][ADDR_W-1:0] w_spec_nxt_mem;
   logic [PTR_W-1:0]                w_spec_nxt_ptr;
   logic [CNT_W-1:0]                w_spec_nxt_cnt;
   logic                            w_spec_wrap;

   logic                            w_unused;
   logic                            r_ovf;

   // Architectural copy, driven only by retirement.
   ra_spec_stack_core #(.DEPTH(RA_DEPTH)) u_cmt (
      .clk         (clk),
      .reset       (reset),
      .i_push_     (bus.commit_call_),
      .i_pop_      (bus.commit_ret_),
      .i_push_val  (ret_target(bus.commit_pc)),
      .i_load_     (1'b1),
      .i_load_mem  ('0),
      .i_load_ptr  ('0),
      .i_load_cnt  ('0),
      .o_mem       (w_cmt_mem),
      .o_ptr       (w_cmt_ptr),
      .o_cnt       (w_cmt_cnt),
      .o_nxt_mem_c (w_cmt_nxt_mem),
      .o_nxt_ptr_c (w_cmt_nxt_ptr),
      .o_nxt_cnt_c (w_cmt_nxt_cnt),
      .o_wrap_c    (w_cmt_wrap)
   );

   // Speculative copy; flush loads the committed next state, so same-cycle retirements survive.
   ra_spec_stack_core #(.DEPTH(RA_DEPTH)) u_spec (
      .clk         (clk),
      .reset       (reset),
      .i_push_     (bus.fetch_call_),
      .i_pop_      (bus.fetch_ret_),
      .i_push_val  (ret_target(bus.fetch_pc)),
      .i_load_     (bus.flush_),
      .i_load_mem  (w_cmt_nxt_mem),
      .i_load_ptr  (w_cmt_nxt_ptr),
      .i_load_cnt  (w_cmt_nxt_cnt),
      .o_mem       (w_spec_mem),
      .o_ptr       (w_spec_ptr),
      .o_cnt       (w_spec_cnt),
      .o_nxt_mem_c (w_spec_nxt_mem),
      .o_nxt_ptr_c (w_spec_nxt_ptr),
      .o_nxt_cnt_c (w_spec_nxt_cnt),
      .o_wrap_c    (w_spec_wrap)
   );

   assign w_unused = ^{w_cmt_mem, w_cmt_ptr, w_cmt_cnt, w_cmt_wrap,
                       w_spec_nxt_mem, w_spec_nxt_ptr, w_spec_nxt_cnt};

   // Wrap is already suppressed by a load, so flush never raises ovf.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_ovf <= 1'b0;
      else       r_ovf <= w_spec_wrap;
   end

   assign bus.ret_v    = (w_spec_cnt != '0);
   assign bus.ret_addr = w_spec_mem[w_spec_ptr];
   assign bus.ovf      = r_ovf;

endmodule

// File: tb/tb_ra_spec_stack.sv
// Directed checks of the speculative return-address stack with a 4-entry depth.
module tb_ra_spec_stack;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   ra_spec_stack_if u_if ();

   ra_spec_stack #(.RA_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      u_if.fetch_call_  = 1'b1;
      u_if.fetch_ret_   = 1'b1;
      u_if.commit_call_ = 1'b1;
      u_if.commit_ret_  = 1'b1;
      u_if.flush_       = 1'b1;
      u_if.fetch_pc     = '0;
      u_if.commit_pc    = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic fcall(input logic [31:0] pc);
      u_if.fetch_call_ = 1'b0;
      u_if.fetch_pc    = pc;
   endtask

   task automatic fret();
      u_if.fetch_ret_ = 1'b0;
   endtask

   task automatic check_top(input string tag, input logic v, input logic [31:0] addr);
      check({tag, ".v"}, 32'(u_if.ret_v), 32'(v));
      if (v) check({tag, ".addr"}, u_if.ret_addr, addr);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      idle();
      reset = 1'b1;
      #12;
      check("rst.v", 32'(u_if.ret_v), 32'd0);
      check("rst.addr", u_if.ret_addr, 32'h0);
      check("rst.ovf", 32'(u_if.ovf), 32'd0);
      reset = 1'b0;
      tick();

      // Test 1: async reset mid-operation
      fcall(32'h10); tick();
      fcall(32'h20); tick();
      fcall(32'h30); tick();
      check_top("t1.pre", 1'b1, 32'h34);
      #2 reset = 1'b1;
      #1;
      check("t1.v", 32'(u_if.ret_v), 32'd0);
      check("t1.addr", u_if.ret_addr, 32'h0);
      check("t1.ovf", 32'(u_if.ovf), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Test 2: basic push/pop and underflow
      fcall(32'h100); tick();
      fcall(32'h200); tick();
      check_top("t2.push2", 1'b1, 32'h204);
      fret(); tick();
      check_top("t2.pop1", 1'b1, 32'h104);
      fret(); tick();
      check_top("t2.pop2", 1'b0, 32'h0);
      fret(); tick();
      check_top("t2.underflow", 1'b0, 32'h0);
      check("t2.ovf", 32'(u_if.ovf), 32'd0);
      fcall(32'h600); tick();
      check_top("t2.after", 1'b1, 32'h604);
      fret(); tick();
      check_top("t2.cnt0", 1'b0, 32'h0);

      // Test 3: overflow on the fifth push into a 4-deep stack
      for (int i = 1; i <= 4; i++) begin
         fcall(32'(i * 16)); tick();
         check("t3.ovf_lo", 32'(u_if.ovf), 32'd0);
      end
      fcall(32'h50); tick();
      check("t3.ovf_hi", 32'(u_if.ovf), 32'd1);
      check_top("t3.top", 1'b1, 32'h54);
      tick();
      check("t3.ovf_pulse", 32'(u_if.ovf), 32'd0);
      fret(); tick();
      check_top("t3.pop1", 1'b1, 32'h44);
      fret(); tick();
      check_top("t3.pop2", 1'b1, 32'h34);
      fret(); tick();
      check_top("t3.pop3", 1'b1, 32'h24);
      fret(); tick();
      check_top("t3.pop4", 1'b0, 32'h0);

      // Test 4: flush restores committed state
      u_if.commit_call_ = 1'b0;
      u_if.commit_pc    = 32'h100;
      fcall(32'h100); tick();
      fcall(32'h300); tick();
      fret(); tick();
      fcall(32'h300); tick();
      check_top("t4.pre", 1'b1, 32'h304);
      u_if.flush_ = 1'b0; tick();
      check_top("t4.flush", 1'b1, 32'h104);
      check("t4.ovf", 32'(u_if.ovf), 32'd0);
      fret(); tick();
      check_top("t4.cnt1", 1'b0, 32'h0);

      // Test 5: flush picks up a same-cycle retired call, ignores fetch
      u_if.commit_ret_ = 1'b0; tick();
      u_if.flush_       = 1'b0;
      u_if.commit_call_ = 1'b0;
      u_if.commit_pc    = 32'h500;
      fcall(32'h900); tick();
      check_top("t5.flush", 1'b1, 32'h504);
      check("t5.ovf", 32'(u_if.ovf), 32'd0);
      fret(); tick();
      check_top("t5.cnt1", 1'b0, 32'h0);

      // Test 6: push and pop in the same cycle
      fcall(32'h100); tick();
      check_top("t6.pre", 1'b1, 32'h104);
      fcall(32'h700); fret(); tick();
      check_top("t6.replace", 1'b1, 32'h704);
      check("t6.ovf", 32'(u_if.ovf), 32'd0);
      fret(); tick();
      check_top("t6.cnt1", 1'b0, 32'h0);
      fcall(32'h700); fret(); tick();
      check_top("t6.empty", 1'b1, 32'h704);
      fret(); tick();
      check_top("t6.empty_cnt1", 1'b0, 32'h0);

      // Flush while full with a fetch push pending: no ovf
      for (int i = 0; i < 4; i++) begin
         fcall(32'h1000 + 32'(i)); tick();
      end
      u_if.flush_ = 1'b0;
      fcall(32'h2000); tick();
      check("t7.ovf", 32'(u_if.ovf), 32'd0);
      check_top("t7.top", 1'b1, 32'h504);

      // Address wrap of pc + 4
      fcall(32'hFFFF_FFFE); tick();
      check_top("t8.wrap", 1'b1, 32'h0000_0002);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
